// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with mid-bit sampling, holding register,
//            framing-error and overrun status.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 6
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rxD,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rdrf,
  output logic       ferr,
  output logic       oerr
);

  localparam logic [15:0] c_half_last = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] c_bit_last  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_sync1;
  logic        r_rx_s;
  logic [15:0] r_baud_cnt;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shreg;
  logic [7:0]  r_rx_data;
  logic        r_rdrf;
  logic        r_ferr;
  logic        r_oerr;

  logic        w_start_ok;
  logic        w_data_smp;
  logic        w_stop_good;
  logic        w_stop_bad;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rxD;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    w_data_smp   = 1'b0;
    w_stop_good  = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (r_baud_cnt == c_half_last) begin
          if (!r_rx_s) begin
            w_start_ok   = 1'b1;
            w_state_next = S_DATA;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (r_baud_cnt == c_bit_last) begin
          w_data_smp = 1'b1;
          if (r_bit_cnt == 4'd7) begin
            w_state_next = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (r_baud_cnt == c_bit_last) begin
          if (r_rx_s) begin
            w_stop_good  = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_stop_bad   = 1'b1;
            w_state_next = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) must go high before another frame can start
        if (r_rx_s) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_baud_cnt <= 16'd0;
      r_bit_cnt  <= 4'd0;
      r_shreg    <= 8'h00;
    end else begin
      if ((w_state_next != r_state) || w_data_smp) begin
        r_baud_cnt <= 16'd0;
      end else if (r_state inside {S_START, S_DATA, S_STOP}) begin
        r_baud_cnt <= r_baud_cnt + 16'd1;
      end else begin
        r_baud_cnt <= 16'd0;
      end

      if (w_start_ok) begin
        r_bit_cnt <= 4'd0;
      end else if (w_data_smp) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end

      if (w_data_smp) begin
        r_shreg <= {r_rx_s, r_shreg[7:1]};
      end
    end
  end

  // Completion outranks rd_ack for rdrf; rd_ack still clears stale status
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_rx_data <= 8'h00;
      r_rdrf    <= 1'b0;
      r_ferr    <= 1'b0;
      r_oerr    <= 1'b0;
    end else begin
      if (w_stop_good) begin
        r_rx_data <= r_shreg;
      end

      if (w_stop_good) begin
        r_rdrf <= 1'b1;
      end else if (rd_ack) begin
        r_rdrf <= 1'b0;
      end

      if (w_stop_bad) begin
        r_ferr <= 1'b1;
      end else if (rd_ack) begin
        r_ferr <= 1'b0;
      end

      if (w_stop_good && r_rdrf && !rd_ack) begin
        r_oerr <= 1'b1;
      end else if (rd_ack) begin
        r_oerr <= 1'b0;
      end
    end
  end

  assign rx_data = r_rx_data;
  assign rdrf    = r_rdrf;
  assign ferr    = r_ferr;
  assign oerr    = r_oerr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx with a byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB    = 6;
  localparam int HALF   = CPB / 2;
  localparam int DONE_K = 2 + HALF + 9 * CPB;
  localparam int FRAME  = 10 * CPB;

  logic       clk;
  logic       clr;
  logic       rxD;
  logic       rd_ack;
  logic [7:0] rx_data;
  logic       rdrf;
  logic       ferr;
  logic       oerr;

  int         n_checks;
  int         n_fail;
  int         rise_k;
  logic [7:0] sb_q[$];
  logic [7:0] last_byte;

  uart_rx #(.CLKS_PER_BIT(CPB)) u_dut (
    .clk     (clk),
    .clr     (clr),
    .rxD     (rxD),
    .rd_ack  (rd_ack),
    .rx_data (rx_data),
    .rdrf    (rdrf),
    .ferr    (ferr),
    .oerr    (oerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rxD = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; inputs change on negedge, the following posedge is e0+k
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input int ack_k, input int abort_k);
    logic [9:0] fr;
    logic       last;
    bit         aborted;
    fr      = {stop, data, 1'b0};
    last    = rdrf;
    rise_k  = -1;
    aborted = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k == abort_k) begin
        clr     = 1'b0;
        rxD     = 1'b1;
        rd_ack  = 1'b0;
        aborted = 1;
        break;
      end
      rxD    = fr[k / CPB];
      rd_ack = (k == ack_k);
      @(negedge clk);
      if (rdrf && !last && rise_k < 0) rise_k = k;
      last = rdrf;
    end
    rd_ack = 1'b0;
    if (!aborted && stop) sb_q.push_back(data);
  endtask

  task automatic check_frame();
    logic [7:0] exp;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      chk("rx_data", {24'd0, rx_data}, {24'd0, exp});
      chk("rdrf", {31'd0, rdrf}, 32'd1);
      last_byte = exp;
    end
  endtask

  task automatic ack_and_check();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    chk("ack_rdrf", {31'd0, rdrf}, 32'd0);
    chk("ack_ferr", {31'd0, ferr}, 32'd0);
    chk("ack_oerr", {31'd0, oerr}, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    n_checks  = 0;
    n_fail    = 0;
    last_byte = 8'h00;
    clr       = 1'b0;
    rxD       = 1'b1;
    rd_ack    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_rdrf", {31'd0, rdrf}, 32'd0);
    chk("rst_ferr", {31'd0, ferr}, 32'd0);
    chk("rst_oerr", {31'd0, oerr}, 32'd0);
    clr = 1'b1;
    idle(4);

    // Basic frame with latency check
    send_frame(8'hA5, 1'b1, -1, -1);
    chk("a5_latency", rise_k, DONE_K);
    check_frame();
    chk("a5_ferr", {31'd0, ferr}, 32'd0);
    chk("a5_oerr", {31'd0, oerr}, 32'd0);
    idle(3);
    ack_and_check();

    // Short low pulses are rejected, HALF+1 is accepted
    rxD = 1'b0;
    repeat (2) @(negedge clk);
    idle(80);
    chk("glitch2_rdrf", {31'd0, rdrf}, 32'd0);
    chk("glitch2_ferr", {31'd0, ferr}, 32'd0);
    chk("glitch2_data", {24'd0, rx_data}, {24'd0, last_byte});
    rxD = 1'b0;
    repeat (HALF) @(negedge clk);
    idle(80);
    chk("glitch3_rdrf", {31'd0, rdrf}, 32'd0);
    rxD = 1'b0;
    repeat (HALF + 1) @(negedge clk);
    idle(80);
    sb_q.push_back(8'hFF);
    check_frame();
    ack_and_check();

    // Framing error followed by a break, then a good frame
    send_frame(8'h3C, 1'b0, -1, -1);
    repeat (20) @(negedge clk);
    chk("fe_ferr", {31'd0, ferr}, 32'd1);
    chk("fe_rdrf", {31'd0, rdrf}, 32'd0);
    chk("fe_data", {24'd0, rx_data}, {24'd0, last_byte});
    idle(80);
    chk("fe_nobrk_rdrf", {31'd0, rdrf}, 32'd0);
    send_frame(8'h81, 1'b1, -1, -1);
    check_frame();
    chk("fe_sticky", {31'd0, ferr}, 32'd1);
    idle(2);
    ack_and_check();

    // Bad stop coinciding with rd_ack leaves ferr set
    send_frame(8'h55, 1'b0, DONE_K, -1);
    idle(6);
    chk("fe_ack_ferr", {31'd0, ferr}, 32'd1);
    ack_and_check();

    // Overrun, then the same pair with rd_ack on the completion edge
    send_frame(8'h12, 1'b1, -1, -1);
    check_frame();
    idle(2);
    send_frame(8'h34, 1'b1, -1, -1);
    check_frame();
    chk("ovr_oerr", {31'd0, oerr}, 32'd1);
    idle(2);
    ack_and_check();
    send_frame(8'h12, 1'b1, -1, -1);
    check_frame();
    idle(2);
    send_frame(8'h34, 1'b1, DONE_K, -1);
    check_frame();
    chk("ovr_ack_oerr", {31'd0, oerr}, 32'd0);
    chk("ovr_ack_ferr", {31'd0, ferr}, 32'd0);

    // Reset mid-frame at bit 4
    send_frame(8'hFF, 1'b1, -1, 5 * CPB + 3);
    @(negedge clk);
    chk("mrst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("mrst_rdrf", {31'd0, rdrf}, 32'd0);
    chk("mrst_ferr", {31'd0, ferr}, 32'd0);
    chk("mrst_oerr", {31'd0, oerr}, 32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    idle(4);
    send_frame(8'h0F, 1'b1, -1, -1);
    check_frame();
    chk("mrst_post_ferr", {31'd0, ferr}, 32'd0);
    chk("mrst_post_oerr", {31'd0, oerr}, 32'd0);
    idle(2);
    ack_and_check();

    // Back-to-back random stream, previous byte acked at each new start
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 0, -1);
      chk("lb_latency", rise_k, DONE_K);
      check_frame();
      chk("lb_ferr", {31'd0, ferr}, 32'd0);
      chk("lb_oerr", {31'd0, oerr}, 32'd0);
    end
    idle(2);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial 8N1 UART receiver: the receive half of the team's UART, the counterpart of the existing transmitter. It synchronises the asynchronous `rxD` line, detects a start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. It then presents the byte on a holding register with a full flag, plus framing-error and overrun status, for a host-side consumer.

## Interface
- `CLKS_PER_BIT`, default 6: clock cycles per serial bit; legal range 4..65535.
- `clk`  in  1: clock, all state updates on the rising edge.
- `clr`  in  1: reset, asynchronous, active-low.
- `rxD`  in  1: serial line, idle high, asynchronous to `clk`.
- `rd_ack`  in  1: one-cycle pulse from the consumer; clears `rdrf`, `ferr` and `oerr`.
- `rx_data`  out  8: last correctly framed byte.
- `rdrf`  out  1: receive data register full; `rx_data` holds an unread byte.
- `ferr`  out  1: sticky framing error (stop bit sampled low).
- `oerr`  out  1: sticky overrun (byte completed while `rdrf` was already 1).

## Operation
- Synchroniser: 2-flop chain on `rxD` produces `rx_s`; both flops reset to 1. The FSM reads only `rx_s`.
- Counters: `baud_cnt` is 16 bits and clears on every state entry. `bit_cnt` is 4 bits. `HALF = CLKS_PER_BIT/2` (integer floor).
- States and transitions:
  - IDLE: `rx_s==0` -> START.
  - START: `baud_cnt` increments. At `baud_cnt==HALF-1`, sample `rx_s`:
    - 0 -> DATA, with `bit_cnt=0`.
    - 1 -> IDLE (false start / glitch rejected).
  - DATA: at `baud_cnt==CLKS_PER_BIT-1`, sample `rx_s` into `shreg[7]` with `shreg` shifted right (LSB-first), then `bit_cnt+1`, `baud_cnt=0`. After the 8th sample -> STOP.
  - STOP: at `baud_cnt==CLKS_PER_BIT-1`, sample `rx_s`:
    - 1: `rx_data<=shreg`, `rdrf<=1`; if `rdrf` was already 1 and no `rd_ack` this cycle, `oerr<=1` (new byte overwrites). -> IDLE.
    - 0: `ferr<=1`; `rx_data` and `rdrf` unchanged; byte discarded. -> WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s==1`, then -> IDLE. A break or stuck-low line never produces repeated frames.
- `rd_ack` clears `rdrf`, `ferr` and `oerr` on the next edge, in any state.
- Simultaneous `rd_ack` and good-stop completion: completion wins. `rdrf` stays 1 with the new byte, `oerr` stays 0, and `ferr` is cleared.
- Simultaneous `rd_ack` and bad-stop completion: `ferr` ends at 1.
- Reset, at any time including mid-frame: state IDLE, counters 0, `shreg=0`, synchroniser=1, `rx_data=8'h00`, `rdrf=0`, `ferr=0`, `oerr=0`. No partial byte is ever exposed.

## Timing
- Edge e0 is the first `clk` edge at which `rxD` is sampled low.
- `rx_s` goes low after e1. START is entered at e2.
- Start sample at e2+HALF. Data bit i (0..7) sampled at e2+HALF+(i+1)·CLKS_PER_BIT. Stop sample at e2+HALF+9·CLKS_PER_BIT.
- `rdrf` is high after edge e0+2+HALF+9·CLKS_PER_BIT; with the default this is e0+59. `rx_data` is valid in the same cycle.
- Minimum line-low width for start acceptance: HALF+1 cycles; shorter pulses are rejected.
- Back-to-back frames: the next start edge may occur any time after the stop sample. IDLE re-arms the cycle after the stop sample.
- Tolerated baud mismatch between ends: about ±4% at `CLKS_PER_BIT`≥16. At the default of 6, transmitter and receiver must share the same bit period exactly.
- Outputs are registered; no combinational path from `rxD` or `rd_ack` to any output.

## Test plan
- Default parameter, frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), e0=0 -> `rdrf` rises after edge 59, `rx_data=8'hA5`, `ferr=oerr=0`; `rd_ack` pulse -> `rdrf=0` next cycle.
- `rxD` low for 2 cycles, then high -> FSM returns to IDLE; `rdrf`, `ferr` and `rx_data` remain 0.
- Frame 0x3C with stop bit low, line held low 20 more cycles -> `ferr=1`, `rdrf=0`, `rx_data` unchanged; no new frame is started until the line goes high; a following good 0x81 -> `rx_data=8'h81`, `rdrf=1`, `ferr` still 1 until `rd_ack`.
- Frames 0x12 then 0x34 with no `rd_ack` -> `rx_data=8'h34`, `rdrf=1`, `oerr=1`. Repeat with `rd_ack` on the exact completion cycle of 0x34 -> `rdrf=1`, `oerr=0`.
- `clr` asserted at bit 4 of frame 0xFF, released, then frame 0x0F sent -> all outputs 0 during reset; afterwards `rx_data=8'h0F` with no corruption.
- Loopback with the team's transmitter at a matched bit period, 256 random bytes -> every byte received in order; `ferr` and `oerr` never set.
